// File: rtl/pb_conditioner_pkg.sv
// Package: pb_conditioner_pkg
// Purpose: shared defaults and helper types for the stopwatch push-button
//          front end (pb_conditioner and its pb_debounce sub-module).
// Contents:
//   PB_TICK_DIV / PB_DEB_DEPTH / PB_LONG_TICKS - default parameter values
//                                                (100 MHz clock, 400 Hz sampling)
//   deb_act_e  - what a debounce sample tick does to the debounced level
//   deb_decide - maps the post-shift sample window to a deb_act_e
//   pb_evt_t   - one bit per event channel (start press, clear press, long clear)
package pb_conditioner_pkg;

    localparam int PB_TICK_DIV   = 32'd250000;
    localparam int PB_DEB_DEPTH  = 32'd4;
    localparam int PB_LONG_TICKS = 32'd400;

    typedef enum logic [1:0] {
        DEB_HOLD = 2'd0,
        DEB_SET  = 2'd1,
        DEB_CLR  = 2'd2
    } deb_act_e;

    typedef struct packed {
        logic start;
        logic clr;
        logic long_clr;
    } pb_evt_t;

    // A unanimous window moves the level; anything mixed leaves it alone.
    function automatic deb_act_e deb_decide(input logic all_ones, input logic all_zeros);
        deb_act_e act;
        if (all_ones) begin
            act = DEB_SET;
        end else if (all_zeros) begin
            act = DEB_CLR;
        end else begin
            act = DEB_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Module: pb_debounce
// Purpose: one push-button channel: two-flop synchroniser, DEB_DEPTH-sample
//          shift register clocked by the shared sample tick, debounced level
//          and a registered single-cycle press (0->1) event.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   raw   in  raw button, asynchronous to clk (1 = pressed)
//   tick  in  shared debounce sample strobe
//   lvl   out debounced level (registered)
//   press out one-cycle pulse, one cycle after lvl rises (registered)
module pb_debounce
    import pb_conditioner_pkg::*;
#(
    parameter int DEB_DEPTH = PB_DEB_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic lvl,
    output logic press
);

    logic                 sync1_r;
    logic                 sync2_r;
    logic [DEB_DEPTH-1:0] shreg_r;
    logic [DEB_DEPTH-1:0] shreg_nxt_s;
    deb_act_e             act_s;
    logic                 lvl_r;
    logic                 lvl_d_r;
    logic                 press_r;

    // Two-flop synchroniser; the only reader of the raw pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Post-shift window and the level decision it implies.
    always_comb begin
        shreg_nxt_s = {shreg_r[DEB_DEPTH-2:0], sync2_r};
        act_s       = deb_decide(&shreg_nxt_s, ~|shreg_nxt_s);
    end

    // Sample window and debounced level advance only on the sample tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= {DEB_DEPTH{1'b0}};
            lvl_r   <= 1'b0;
        end else if (tick) begin
            shreg_r <= shreg_nxt_s;
            case (act_s)
                DEB_SET: lvl_r <= 1'b1;
                DEB_CLR: lvl_r <= 1'b0;
                default: lvl_r <= lvl_r;
            endcase
        end else begin
            shreg_r <= shreg_r;
            lvl_r   <= lvl_r;
        end
    end

    // Rising-edge detector; releases deliberately produce nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            lvl_d_r <= lvl_r;
            press_r <= lvl_r & ~lvl_d_r;
        end
    end

    assign lvl   = lvl_r;
    assign press = press_r;

endmodule

// File: rtl/pb_conditioner.sv
// Module: pb_conditioner
// Purpose: stopwatch push-button front end. Debounces start/stop and clear,
//          detects presses, detects a long hold of clear, and hands each event
//          to the consumer as a single pulse on a cycle where cons_en is high.
// Ports:
//   clk            in  system clock
//   rst            in  asynchronous active-high reset
//   pb_start_raw   in  raw start/stop button (1 = pressed)
//   pb_clr_raw     in  raw clear button (1 = pressed)
//   cons_en        in  consumer clock enable; pulses only appear while it is 1
//   start_pulse    out one cycle per start press, coincident with cons_en
//   clr_pulse      out one cycle per clear press, coincident with cons_en
//   long_clr_pulse out one cycle per clear hold of LONG_TICKS ticks
//   start_lvl      out debounced start level
//   clr_lvl        out debounced clear level
module pb_conditioner
    import pb_conditioner_pkg::*;
#(
    parameter int TICK_DIV   = PB_TICK_DIV,
    parameter int DEB_DEPTH  = PB_DEB_DEPTH,
    parameter int LONG_TICKS = PB_LONG_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_start_raw,
    input  logic pb_clr_raw,
    input  logic cons_en,
    output logic start_pulse,
    output logic clr_pulse,
    output logic long_clr_pulse,
    output logic start_lvl,
    output logic clr_lvl
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_TICKS - 1);

    logic [TW-1:0] tick_cnt_r;
    logic          tick_s;
    logic          start_lvl_s;
    logic          clr_lvl_s;
    logic          start_press_s;
    logic          clr_press_s;
    logic [HW-1:0] hold_r;
    logic          long_evt_r;
    pb_evt_t       evt_s;
    pb_evt_t       pend_r;
    pb_evt_t       pend_nxt_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Shared sample-tick divider, wraps after TICK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    pb_debounce #(
        .DEB_DEPTH (DEB_DEPTH)
    ) u_deb_start (
        .clk   (clk),
        .rst   (rst),
        .raw   (pb_start_raw),
        .tick  (tick_s),
        .lvl   (start_lvl_s),
        .press (start_press_s)
    );

    pb_debounce #(
        .DEB_DEPTH (DEB_DEPTH)
    ) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (pb_clr_raw),
        .tick  (tick_s),
        .lvl   (clr_lvl_s),
        .press (clr_press_s)
    );

    // Hold counter: counts ticks seen with clear held, saturating so it
    // cannot wrap and re-fire during a very long hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= {HW{1'b0}};
        end else if (!clr_lvl_s) begin
            hold_r <= {HW{1'b0}};
        end else if (tick_s && (hold_r != HOLD_MAX)) begin
            hold_r <= hold_r + HW'(1);
        end else begin
            hold_r <= hold_r;
        end
    end

    // Long-hold event on the single tick where the counter reaches its ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_evt_r <= 1'b0;
        end else begin
            long_evt_r <= tick_s & clr_lvl_s & (hold_r == HOLD_PRE);
        end
    end

    // New events always win over a consume in the same cycle, so a press that
    // lands exactly as the previous one is taken is never lost.
    always_comb begin
        evt_s          = '0;
        evt_s.start    = start_press_s;
        evt_s.clr      = clr_press_s;
        evt_s.long_clr = long_evt_r;
        pend_nxt_s     = evt_s | (pend_r & ~{3{cons_en}});
    end

    // Pending-event register per channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Pulses are gated by cons_en combinationally so they line up with the
    // consumer's enabled cycle rather than lagging it by one clock.
    assign start_pulse    = pend_r.start    & cons_en;
    assign clr_pulse      = pend_r.clr      & cons_en;
    assign long_clr_pulse = pend_r.long_clr & cons_en;
    assign start_lvl      = start_lvl_s;
    assign clr_lvl        = clr_lvl_s;

endmodule

// File: tb/tb_pb_conditioner.sv
// Testbench for pb_conditioner (TICK_DIV=4, DEB_DEPTH=3, LONG_TICKS=8).
// Table-driven phases, hand-written corner sequences and a randomized run,
// all cross-checked every cycle against a behavioural model of the button rules.
module tb_pb_conditioner;

    localparam int TD = 4;
    localparam int DD = 3;
    localparam int LT = 8;

    logic clk = 1'b0;
    logic rst;
    logic pb_start_raw;
    logic pb_clr_raw;
    logic cons_en;
    logic start_pulse;
    logic clr_pulse;
    logic long_clr_pulse;
    logic start_lvl;
    logic clr_lvl;

    pb_conditioner #(
        .TICK_DIV   (TD),
        .DEB_DEPTH  (DD),
        .LONG_TICKS (LT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pb_start_raw   (pb_start_raw),
        .pb_clr_raw     (pb_clr_raw),
        .cons_en        (cons_en),
        .start_pulse    (start_pulse),
        .clr_pulse      (clr_pulse),
        .long_clr_pulse (long_clr_pulse),
        .start_lvl      (start_lvl),
        .clr_lvl        (clr_lvl)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    int   m_n;                 // edges since reset release
    logic m_h1 [2];            // raw value one edge ago
    logic m_h2 [2];            // raw value two edges ago
    logic m_lvl [2];
    logic m_sq0 [$];           // recent samples, start button
    logic m_sq1 [$];           // recent samples, clear button
    int   m_hold;
    int   m_dq0 [$];           // edge numbers where a pending bit must be set
    int   m_dq1 [$];
    int   m_dq2 [$];
    logic m_pend [3];

    int   gcyc = 0;
    int   cnt_s, cnt_c, cnt_l, cnt_both;
    logic obs_s, obs_c;

    function automatic logic settle(input logic old, input int ones);
        if (ones == DD) return 1'b1;
        else if (ones == 0) return 1'b0;
        else return old;
    endfunction

    function automatic void model_reset();
        m_n = 0;
        m_hold = 0;
        m_sq0.delete();
        m_sq1.delete();
        m_dq0.delete();
        m_dq1.delete();
        m_dq2.delete();
        for (int i = 0; i < 2; i++) begin
            m_h1[i] = 1'b0;
            m_h2[i] = 1'b0;
            m_lvl[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
        for (int i = 0; i < DD; i++) begin
            m_sq0.push_back(1'b0);
            m_sq1.push_back(1'b0);
        end
    endfunction

    function automatic void model_edge(input logic r, input logic rs, input logic rc, input logic ce);
        logic tick, s0, s1, old0, old1, ev0, ev1, ev2;
        int ones0, ones1;
        if (r) begin
            model_reset();
            return;
        end
        m_n++;
        tick = ((m_n % TD) == 0);
        s0 = m_h2[0];
        s1 = m_h2[1];
        m_h2[0] = m_h1[0];
        m_h2[1] = m_h1[1];
        m_h1[0] = rs;
        m_h1[1] = rc;
        old0 = m_lvl[0];
        old1 = m_lvl[1];
        if (tick) begin
            m_sq0.push_back(s0);
            m_sq1.push_back(s1);
            if (m_sq0.size() > DD) void'(m_sq0.pop_front());
            if (m_sq1.size() > DD) void'(m_sq1.pop_front());
            ones0 = 0;
            ones1 = 0;
            foreach (m_sq0[i]) ones0 += int'(m_sq0[i]);
            foreach (m_sq1[i]) ones1 += int'(m_sq1[i]);
            m_lvl[0] = settle(old0, ones0);
            m_lvl[1] = settle(old1, ones1);
        end
        if (!old0 && m_lvl[0]) m_dq0.push_back(m_n + 2);
        if (!old1 && m_lvl[1]) m_dq1.push_back(m_n + 2);
        if (!old1) begin
            m_hold = 0;
        end else if (tick && m_hold < LT) begin
            m_hold++;
            if (m_hold == LT) m_dq2.push_back(m_n + 1);
        end
        ev0 = (m_dq0.size() > 0) && (m_dq0[0] == m_n);
        ev1 = (m_dq1.size() > 0) && (m_dq1[0] == m_n);
        ev2 = (m_dq2.size() > 0) && (m_dq2[0] == m_n);
        if (ev0) void'(m_dq0.pop_front());
        if (ev1) void'(m_dq1.pop_front());
        if (ev2) void'(m_dq2.pop_front());
        m_pend[0] = ev0 | (m_pend[0] & !ce);
        m_pend[1] = ev1 | (m_pend[1] & !ce);
        m_pend[2] = ev2 | (m_pend[2] & !ce);
    endfunction

    // ---------------- checking helpers ----------------
    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // One clock: drive, compare against the model at the negedge, advance.
    task automatic cyc(input logic r, input logic rs, input logic rc, input logic ce);
        rst = r;
        pb_start_raw = rs;
        pb_clr_raw = rc;
        cons_en = ce;
        if (r) model_reset();
        @(negedge clk);
        chk("start_pulse", start_pulse, m_pend[0] & ce);
        chk("clr_pulse", clr_pulse, m_pend[1] & ce);
        chk("long_clr_pulse", long_clr_pulse, m_pend[2] & ce);
        chk("start_lvl", start_lvl, m_lvl[0]);
        chk("clr_lvl", clr_lvl, m_lvl[1]);
        obs_s = (start_pulse === 1'b1);
        obs_c = (clr_pulse === 1'b1);
        if (obs_s) cnt_s++;
        if (obs_c) cnt_c++;
        if (long_clr_pulse === 1'b1) cnt_l++;
        if (obs_s && obs_c) cnt_both++;
        @(posedge clk);
        model_edge(r, rs, rc, ce);
        gcyc++;
        #1;
    endtask

    task automatic clr_counts();
        cnt_s = 0;
        cnt_c = 0;
        cnt_l = 0;
        cnt_both = 0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic rs;
        logic rc;
        logic ce;
        int   len;
        int   e_s;
        int   e_c;
        int   e_l;
        logic e_ls;
        logic e_lc;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int first_k;
        logic rr, rcr, cem;

        model_reset();

        // Reset held with both buttons pressed: outputs stay quiet.
        clr_counts();
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_start_pulse", start_pulse, 1'b0);
        chk("rst_clr_pulse", clr_pulse, 1'b0);
        chk("rst_start_lvl", start_lvl, 1'b0);
        chk("rst_clr_lvl", clr_lvl, 1'b0);
        chk_int("rst_pulse_cnt", cnt_s + cnt_c + cnt_l, 0);
        // Release: first pulse only after three full ticks of stable samples.
        first_k = -1;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1);
            if (obs_s && first_k < 0) first_k = k;
        end
        chk_int("rst_first_pulse_cycle", first_k, 14);
        chk_int("rst_first_both", cnt_both, 1);

        // Table-driven phases from a clean reset.
        do_reset(3);
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 20, 0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 40, 1, 0, 0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 40, 0, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 80, 0, 1, 1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 40, 0, 0, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 40, 0, 0, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 20, 1, 1, 0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 40, 0, 0, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 40, 0, 0, 0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1,  4, 1, 0, 0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 40, 0, 0, 0, 1'b0, 1'b0};
        for (int p = 0; p < 11; p++) begin
            clr_counts();
            for (int i = 0; i < tbl[p].len; i++) cyc(1'b0, tbl[p].rs, tbl[p].rc, tbl[p].ce);
            chk_int($sformatf("tbl%0d_start_cnt", p), cnt_s, tbl[p].e_s);
            chk_int($sformatf("tbl%0d_clr_cnt", p), cnt_c, tbl[p].e_c);
            chk_int($sformatf("tbl%0d_long_cnt", p), cnt_l, tbl[p].e_l);
            chk($sformatf("tbl%0d_start_lvl", p), start_lvl, tbl[p].e_ls);
            chk($sformatf("tbl%0d_clr_lvl", p), clr_lvl, tbl[p].e_lc);
        end

        // Bounce: 5-cycle toggling never gives three equal samples.
        clr_counts();
        for (int i = 0; i < 60; i++) cyc(1'b0, ((i / 5) % 2 == 0), 1'b0, 1'b1);
        chk_int("bounce_no_pulse_while_toggling", cnt_s, 0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk_int("bounce_one_pulse", cnt_s, 1);
        // Short glitches low while held: one and two samples wide.
        clr_counts();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4 * (g + 1); i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        end
        chk_int("glitch_no_pulse", cnt_s, 0);
        chk("glitch_lvl_held", start_lvl, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Handshake: cons_en every 10th cycle, single press.
        clr_counts();
        for (int i = 0; i < 80; i++) cyc(1'b0, (i < 40), 1'b0, (gcyc % 10 == 9));
        chk_int("hs_sparse_one_pulse", cnt_s, 1);
        // Two presses inside one long cons_en gap merge into one pulse.
        clr_counts();
        for (int i = 0; i < 80; i++) cyc(1'b0, ((i / 20) % 2 == 0), 1'b0, 1'b0);
        chk_int("hs_gap_no_pulse", cnt_s, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_int("hs_merge_on_enable", cnt_s, 1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_int("hs_merge_single", cnt_s, 1);

        // Simultaneous presses pulse in the same cycle.
        clr_counts();
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_int("simul_same_cycle", cnt_both, 1);
        chk_int("simul_start_cnt", cnt_s, 1);
        // Reset while events are pending discards them.
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset(3);
        clr_counts();
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_int("rst_pend_discard", cnt_s + cnt_c + cnt_l, 0);

        // Randomized segments checked cycle by cycle against the model.
        for (int s = 0; s < 150; s++) begin
            int len;
            logic dense;
            if ($urandom_range(0, 40) == 0) do_reset(2);
            len   = $urandom_range(1, 30);
            rr    = 1'($urandom_range(0, 1));
            rcr   = ($urandom_range(0, 3) == 0) ? 1'b1 : rr ^ 1'($urandom_range(0, 1));
            dense = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                cem = dense ? 1'b1 : 1'($urandom_range(0, 1));
                cyc(1'b0, rr, rcr, cem);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
